// File: rtl/exe_stage_module.sv
// Execute stage: operand forwarding, Val2 shifter, ALU, NZCV status and EXE/MEM register.
// Latency: branch and status_next are combinational; results are registered one cycle later.
// Backpressure: freeze holds the EXE/MEM register and the status register; branch outputs stay live.
module exe_stage_module #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int REG_A_W = 4,
  parameter int CMD_W   = 4,
  parameter int SIMM_W  = 24,
  parameter int SHOP_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               mem_read_en_in,
  input  logic               mem_write_en_in,
  input  logic               wb_enable_in,
  input  logic               immediate_in,
  input  logic               branch_taken_in,
  input  logic               status_write_enable_in,
  input  logic [CMD_W-1:0]   execute_command_in,
  input  logic [DATA_W-1:0]  reg_file_in1,
  input  logic [DATA_W-1:0]  reg_file_in2,
  input  logic [REG_A_W-1:0] dest_reg_in,
  input  logic [SIMM_W-1:0]  signed_immediate_in,
  input  logic [SHOP_W-1:0]  shift_operand_in,
  input  logic [1:0]         sel_src1,
  input  logic [1:0]         sel_src2,
  input  logic [DATA_W-1:0]  mem_alu_result,
  input  logic [DATA_W-1:0]  wb_value,
  output logic               branch_taken_out,
  output logic [ADDR_W-1:0]  branch_address_out,
  output logic [3:0]         status_next_out,
  output logic [3:0]         status_reg_out,
  output logic [DATA_W-1:0]  alu_result_out,
  output logic [DATA_W-1:0]  store_value_out,
  output logic [REG_A_W-1:0] dest_reg_out,
  output logic               wb_enable_out,
  output logic               mem_read_en_out,
  output logic               mem_write_en_out
);

  localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;

  logic [DATA_W-1:0]   op1, fwd2, val2, alu_res;
  logic [DATA_W:0]     sum;
  logic [3:0]          alu_flags;
  logic [DATA_W-1:0]   imm_ext;
  logic [2*DATA_W-1:0] rot_dbl;
  logic [4:0]          sh_amt;
  logic [ADDR_W-1:0]   simm_ext;

  // Forwarding muxes; code 11 falls back to the register file like 00.
  always_comb begin
    op1  = reg_file_in1;
    fwd2 = reg_file_in2;
    if (sel_src1 == 2'b01)      op1 = mem_alu_result;
    else if (sel_src1 == 2'b10) op1 = wb_value;
    if (sel_src2 == 2'b01)      fwd2 = mem_alu_result;
    else if (sel_src2 == 2'b10) fwd2 = wb_value;
  end

  // Second operand: rotated 8-bit immediate, 12-bit memory offset, or shifted register.
  always_comb begin
    imm_ext = {{(DATA_W-8){1'b0}}, shift_operand_in[7:0]};
    sh_amt  = shift_operand_in[11:7];
    rot_dbl = '0;
    val2    = fwd2;
    if (immediate_in) begin
      rot_dbl = {imm_ext, imm_ext} >> {shift_operand_in[11:8], 1'b0};
      val2    = rot_dbl[DATA_W-1:0];
    end else if (mem_read_en_in || mem_write_en_in) begin
      val2 = {{(DATA_W-SHOP_W){1'b0}}, shift_operand_in};
    end else begin
      case (shift_operand_in[6:5])
        2'b00: val2 = fwd2 << sh_amt;
        2'b01: val2 = fwd2 >> sh_amt;
        2'b10: val2 = $unsigned($signed(fwd2) >>> sh_amt);
        default: begin
          rot_dbl = {fwd2, fwd2} >> sh_amt;
          val2    = rot_dbl[DATA_W-1:0];
        end
      endcase
    end
  end

  // ALU and flag generation; arithmetic uses op1 + ~Val2 + carry-in for subtraction so C is NOT borrow.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_flags = status_reg_out;
    case (execute_command_in)
      CMD_ADD: sum = {1'b0, op1} + {1'b0, val2};
      CMD_ADC: sum = {1'b0, op1} + {1'b0, val2} + {{DATA_W{1'b0}}, status_reg_out[1]};
      CMD_SUB: sum = {1'b0, op1} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1};
      CMD_SBC: sum = {1'b0, op1} + {1'b0, ~val2} + {{DATA_W{1'b0}}, status_reg_out[1]};
      default: sum = '0;
    endcase
    case (execute_command_in)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = op1 & val2;
      CMD_ORR: alu_res = op1 | val2;
      CMD_EOR: alu_res = op1 ^ val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res = sum[DATA_W-1:0];
      default: alu_res = '0;
    endcase
    case (execute_command_in)
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
        alu_flags[3] = alu_res[DATA_W-1];
        alu_flags[2] = (alu_res == '0);
      end
      CMD_ADD, CMD_ADC: begin
        alu_flags[3] = alu_res[DATA_W-1];
        alu_flags[2] = (alu_res == '0);
        alu_flags[1] = sum[DATA_W];
        alu_flags[0] = (op1[DATA_W-1] == val2[DATA_W-1]) && (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        alu_flags[3] = alu_res[DATA_W-1];
        alu_flags[2] = (alu_res == '0);
        alu_flags[1] = sum[DATA_W];
        alu_flags[0] = (op1[DATA_W-1] != val2[DATA_W-1]) && (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
      default: alu_flags = status_reg_out;
    endcase
  end

  // Branch target and early status for the decode condition check.
  always_comb begin
    simm_ext           = {{(ADDR_W-SIMM_W){signed_immediate_in[SIMM_W-1]}}, signed_immediate_in};
    branch_address_out = pc_in + (simm_ext << 2);
    branch_taken_out   = branch_taken_in;
    status_next_out    = status_write_enable_in ? alu_flags : status_reg_out;
  end

  // NZCV status register; reset wins over freeze.
  always_ff @(posedge clk) begin
    if (rst)                                    status_reg_out <= '0;
    else if (status_write_enable_in && !freeze) status_reg_out <= alu_flags;
  end

  // EXE/MEM pipeline register, held while the memory stage stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_out   <= '0;
      store_value_out  <= '0;
      dest_reg_out     <= '0;
      wb_enable_out    <= 1'b0;
      mem_read_en_out  <= 1'b0;
      mem_write_en_out <= 1'b0;
    end else if (!freeze) begin
      alu_result_out   <= alu_res;
      store_value_out  <= fwd2;
      dest_reg_out     <= dest_reg_in;
      wb_enable_out    <= wb_enable_in;
      mem_read_en_out  <= mem_read_en_in;
      mem_write_en_out <= mem_write_en_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_module.sv
// Bench for exe_stage_module: directed cases followed by random traffic against an arithmetic model.
// Latency: registered outputs are checked 1 ns after each rising edge, combinational ones before it.
// Backpressure: freeze is exercised directly and randomly; the model holds state while it is high.
module tb_exe_stage_module;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [31:0] pc_in;
  logic        mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in;
  logic        branch_taken_in, status_write_enable_in;
  logic [3:0]  execute_command_in;
  logic [31:0] reg_file_in1, reg_file_in2;
  logic [3:0]  dest_reg_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_alu_result, wb_value;
  logic        branch_taken_out;
  logic [31:0] branch_address_out;
  logic [3:0]  status_next_out, status_reg_out;
  logic [31:0] alu_result_out, store_value_out;
  logic [3:0]  dest_reg_out;
  logic        wb_enable_out, mem_read_en_out, mem_write_en_out;

  int checks = 0;
  int errors = 0;

  // Model state: what the registered outputs should hold.
  logic [3:0]  m_status;
  logic [31:0] e_alu, e_store;
  logic [3:0]  e_dest;
  logic        e_wb, e_mr, e_mw;
  // Model values for the instruction currently presented.
  logic [31:0] c_res, c_fwd2;
  logic [3:0]  c_flags;

  exe_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .wb_enable_in(wb_enable_in), .immediate_in(immediate_in),
    .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
    .execute_command_in(execute_command_in), .reg_file_in1(reg_file_in1),
    .reg_file_in2(reg_file_in2), .dest_reg_in(dest_reg_in),
    .signed_immediate_in(signed_immediate_in), .shift_operand_in(shift_operand_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_alu_result(mem_alu_result),
    .wb_value(wb_value), .branch_taken_out(branch_taken_out),
    .branch_address_out(branch_address_out), .status_next_out(status_next_out),
    .status_reg_out(status_reg_out), .alu_result_out(alu_result_out),
    .store_value_out(store_value_out), .dest_reg_out(dest_reg_out),
    .wb_enable_out(wb_enable_out), .mem_read_en_out(mem_read_en_out),
    .mem_write_en_out(mem_write_en_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf);
    if (s == 2'd1) return mem_alu_result;
    if (s == 2'd2) return wb_value;
    return rf;
  endfunction

  // Reference ALU: arithmetic done in 64-bit integers, flags derived from range checks.
  task automatic model_eval();
    logic [31:0] a, b;
    longint ua, ub, us, sa, sb, ss;
    int n, cin;
    a = pick(sel_src1, reg_file_in1);
    c_fwd2 = pick(sel_src2, reg_file_in2);
    if (immediate_in) b = ror32({24'd0, shift_operand_in[7:0]}, 2 * int'(shift_operand_in[11:8]));
    else if (mem_read_en_in || mem_write_en_in) b = {20'd0, shift_operand_in};
    else begin
      n = int'(shift_operand_in[11:7]);
      case (shift_operand_in[6:5])
        2'd0: b = c_fwd2 << n;
        2'd1: b = c_fwd2 >> n;
        2'd2: b = $unsigned($signed(c_fwd2) >>> n);
        default: b = ror32(c_fwd2, n);
      endcase
    end
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cin = int'(m_status[1]);
    c_flags = m_status;
    c_res = 32'd0;
    case (execute_command_in)
      4'd2, 4'd3: begin
        if (execute_command_in == 4'd2) cin = 0;
        us = ua + ub + cin; ss = sa + sb + cin;
        c_res = us[31:0];
        c_flags = {c_res[31], c_res == 0, us > 64'sd4294967295, ss > 64'sd2147483647 || ss < -64'sd2147483648};
      end
      4'd4, 4'd5: begin
        cin = (execute_command_in == 4'd4) ? 0 : 1 - cin;
        us = ua - ub - cin; ss = sa - sb - cin;
        c_res = us[31:0];
        c_flags = {c_res[31], c_res == 0, us >= 0, ss > 64'sd2147483647 || ss < -64'sd2147483648};
      end
      4'd1, 4'd9, 4'd6, 4'd7, 4'd8: begin
        case (execute_command_in)
          4'd1: c_res = b;
          4'd9: c_res = ~b;
          4'd6: c_res = a & b;
          4'd7: c_res = a | b;
          default: c_res = a ^ b;
        endcase
        c_flags = {c_res[31], c_res == 0, m_status[1], m_status[0]};
      end
      default: ;
    endcase
  endtask

  // One clock: optional combinational checks, edge, model update, registered checks.
  task automatic step(input bit comb);
    logic [31:0] exp_ba;
    #1;
    model_eval();
    if (comb) begin
      exp_ba = pc_in + 32'(longint'($signed(signed_immediate_in)) * 4);
      chk("branch_addr", branch_address_out, exp_ba);
      chk("branch_taken", {31'd0, branch_taken_out}, {31'd0, branch_taken_in});
      chk("status_next", {28'd0, status_next_out},
          {28'd0, status_write_enable_in ? c_flags : m_status});
    end
    @(posedge clk);
    if (rst) begin
      m_status = 0; e_alu = 0; e_store = 0; e_dest = 0; e_wb = 0; e_mr = 0; e_mw = 0;
    end else if (!freeze) begin
      e_alu = c_res; e_store = c_fwd2; e_dest = dest_reg_in;
      e_wb = wb_enable_in; e_mr = mem_read_en_in; e_mw = mem_write_en_in;
      if (status_write_enable_in) m_status = c_flags;
    end
    #1;
    chk("alu_result", alu_result_out, e_alu);
    chk("store_value", store_value_out, e_store);
    chk("status_reg", {28'd0, status_reg_out}, {28'd0, m_status});
    chk("dest_ctrl", {25'd0, dest_reg_out, wb_enable_out, mem_read_en_out, mem_write_en_out},
        {25'd0, e_dest, e_wb, e_mr, e_mw});
  endtask

  task automatic randomize_inputs();
    pc_in = $urandom; reg_file_in1 = $urandom; reg_file_in2 = $urandom;
    mem_alu_result = $urandom; wb_value = $urandom;
    signed_immediate_in = 24'($urandom); shift_operand_in = 12'($urandom);
    execute_command_in = 4'($urandom); dest_reg_in = 4'($urandom);
    sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
    immediate_in = ($urandom_range(0, 2) == 0);
    mem_read_en_in = ($urandom_range(0, 3) == 0);
    mem_write_en_in = ($urandom_range(0, 3) == 0);
    wb_enable_in = 1'($urandom); branch_taken_in = 1'($urandom);
    status_write_enable_in = 1'($urandom);
  endtask

  task automatic plain();
    freeze = 0; rst = 0; immediate_in = 0; mem_read_en_in = 0; mem_write_en_in = 0;
    sel_src1 = 0; sel_src2 = 0; status_write_enable_in = 0; wb_enable_in = 1;
  endtask

  initial begin
    m_status = 0; e_alu = 0; e_store = 0; e_dest = 0; e_wb = 0; e_mr = 0; e_mw = 0;
    // Reset with arbitrary inputs and freeze high: reset must win.
    randomize_inputs();
    rst = 1; freeze = 1;
    step(0);
    chk("reset_alu", alu_result_out, 32'd0);
    chk("reset_status", {28'd0, status_reg_out}, 32'd0);

    // ADDS 0x7FFFFFFF + 1 -> N and V set.
    plain();
    reg_file_in1 = 32'h7FFF_FFFF; immediate_in = 1; shift_operand_in = 12'h001;
    execute_command_in = 4'b0010; status_write_enable_in = 1; dest_reg_in = 4'd3;
    step(1);
    chk("adds_res", alu_result_out, 32'h8000_0000);
    chk("adds_flags", {28'd0, status_reg_out}, 32'h9);

    // Immediate rotate: 0xFF ror 8.
    plain();
    immediate_in = 1; shift_operand_in = 12'h4FF; execute_command_in = 4'b0001;
    step(1);
    chk("imm_rot", alu_result_out, 32'hFF00_0000);

    // Register ASR #4.
    plain();
    reg_file_in2 = 32'h8000_0000; shift_operand_in = 12'h240; execute_command_in = 4'b0001;
    step(1);
    chk("reg_asr", alu_result_out, 32'hF800_0000);

    // Forwarded op1 plus memory offset.
    plain();
    sel_src1 = 2'b01; mem_alu_result = 32'd5; mem_read_en_in = 1;
    shift_operand_in = 12'd8; execute_command_in = 4'b0010;
    step(1);
    chk("fwd_ldr", alu_result_out, 32'd13);

    // SUBS 3-5 clears C, then SBC 10-2-1.
    plain();
    reg_file_in1 = 32'd3; immediate_in = 1; shift_operand_in = 12'd5;
    execute_command_in = 4'b0100; status_write_enable_in = 1;
    step(1);
    chk("subs_c", {31'd0, status_reg_out[1]}, 32'd0);
    plain();
    reg_file_in1 = 32'd10; immediate_in = 1; shift_operand_in = 12'd2;
    execute_command_in = 4'b0101; status_write_enable_in = 1;
    #1 chk("sbc_next", {28'd0, status_next_out}, 32'h2);
    step(1);
    chk("sbc_res", alu_result_out, 32'd7);

    // Freeze with new inputs plus a backward branch.
    randomize_inputs();
    rst = 0; freeze = 1; pc_in = 32'h100; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 1;
    #1 chk("branch_const", branch_address_out, 32'hF8);
    chk("branch_taken_frz", {31'd0, branch_taken_out}, 32'd1);
    step(1);
    chk("freeze_hold", alu_result_out, 32'd7);

    // Random traffic with occasional reset and frequent freeze.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 40) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage_module.md
Name: exe_stage_module

Overview:
Execute stage plus its EXE/MEM pipeline register, directly downstream of the decode stage's ID/EX register. Builds the second operand (immediate rotate, memory offset, or shifted register), forwards operands, runs the ALU, and owns the NZCV status register. Resolves branch target and taken signal for fetch, and registers results for the memory stage.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, register/ALU width
REG_A_W, 4, register index width
CMD_W, 4, execute command width
SIMM_W, 24, signed branch immediate width
SHOP_W, 12, shift operand width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  hold EXE/MEM register and status register (memory stall)
pc_in  in  ADDR_W  PC+4 of the instruction in EXE
mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in  in  1 each  staged controls from ID/EX
execute_command_in  in  CMD_W  ALU op
reg_file_in1, reg_file_in2  in  DATA_W  Rn, Rm values
dest_reg_in  in  REG_A_W  Rd
signed_immediate_in  in  SIMM_W  branch offset, in words
shift_operand_in  in  SHOP_W  shifter operand field
sel_src1, sel_src2  in  2  forward select: 00 regfile, 01 mem_alu_result, 10 wb_value, 11 regfile
mem_alu_result  in  DATA_W  ALU result held in MEM stage
wb_value  in  DATA_W  WB write data
branch_taken_out  out  1  combinational, equals branch_taken_in
branch_address_out  out  ADDR_W  combinational branch target
status_next_out  out  4  combinational NZCV after this instruction, for ID condition check
status_reg_out  out  4  registered NZCV {N,Z,C,V}
alu_result_out  out  DATA_W  registered
store_value_out  out  DATA_W  registered forwarded Rm
dest_reg_out  out  REG_A_W  registered
wb_enable_out, mem_read_en_out, mem_write_en_out  out  1 each  registered

Behaviour:
- Single clock. Sync reset clears every registered output and status to 0. Reset wins over freeze.
- op1 is reg_file_in1 or a forwarded value per sel_src1. fwd2 is reg_file_in2 or a forwarded value per sel_src2.
- Val2 selection, in priority order:
  - immediate_in: zero-extend shift_operand[7:0], then rotate right by 2*shift_operand[11:8].
  - mem_read_en_in|mem_write_en_in: zero-extend shift_operand[11:0].
  - Otherwise: fwd2 shifted by shift_operand[11:7]. shift_operand[6:5] selects 00 LSL, 01 LSR, 10 ASR, 11 ROR. Amount 0 means no shift.
- Commands:
  - 0001 MOV=Val2
  - 1001 MVN=~Val2
  - 0010 ADD=op1+Val2
  - 0011 ADC=op1+Val2+C
  - 0100 SUB=op1-Val2
  - 0101 SBC=op1-Val2-!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags unchanged.
  - C is the registered status C.
  - LDR/STR are issued as ADD. CMP and TST arrive as SUB and AND with wb_enable=0.
- Flags:
  - N=result[31]; Z=(result==0).
  - ADD/ADC: C=carry out, V=signed overflow.
  - SUB/SBC: C=NOT borrow, V=signed overflow.
  - Logic ops and MOV/MVN: C and V keep their old values.
- status_next_out = status_write_enable_in ? alu_flags : status_reg_out.
- status_reg_out loads alu_flags at the edge when status_write_enable_in && !freeze.
- branch_address_out = pc_in + (sign-extended signed_immediate_in << 2), 32-bit wrap.
- EXE/MEM register: latency 1. Loads at every edge unless freeze; while freeze=1 all registered outputs hold.
- Freeze and branch_taken_in can be high together: branch signals stay combinational and valid; fetch handles ordering.

Test Plan:
- Reset: set rst=1 for 1 cycle with arbitrary inputs → all registered outputs and status_reg_out are 0 next cycle.
- ADDS: op1=0x7FFFFFFF, immediate Val2=1, status_write_enable=1 → alu_result_out=0x80000000, status_reg_out=N1 Z0 C0 V1 one cycle later.
- Immediate rotate: shift_operand=0x4FF, MOV → alu_result_out=0xFF000000. Register shift: fwd2=0x80000000, ASR #4 → 0xF8000000.
- Forwarding: sel_src1=01, mem_alu_result=5, shift_operand offset=8, mem_read_en=1 → alu_result_out=13.
- SUBS then SBC: SUBS 3-5 sets C=0. Next cycle SBC with op1=10, Val2=2 gives 7, and status_next_out matches the same-cycle flags.
- Freeze and branch: freeze=1 with new inputs → outputs hold. pc_in=0x100, signed_immediate=0xFFFFFE → branch_address_out=0xF8.
